// File: rtl/block_mem_responder.sv
// block_mem_responder: fixed-latency 4-word block memory behind valid/ready request/response channels
module block_mem_responder #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 32,
    parameter int WORDS_PER_BLK = 4,
    parameter int LATENCY       = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [WORDS_PER_BLK*DATA_W-1:0] req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [WORDS_PER_BLK*DATA_W-1:0] rsp_rdata
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BLK_W = WORDS_PER_BLK * DATA_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q;
    logic                write_q;
    logic [BLK_W-1:0]    wdata_q, rd_blk;
    logic                rsp_valid_q, rsp_write_q;
    logic [BLK_W-1:0]    rsp_rdata_q;
    logic                accept, access, done;

    // Words are stored XORed with their address so the all-zero power-up image reads back as mem[i] = i
    logic [DATA_W-1:0]   mem_q [2**ADDR_W] = '{default: '0};

    assign accept = (state_q == IDLE) && req_valid;
    assign access = (state_q == BUSY) && (cnt_q == '0);
    assign done   = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? BUSY : access ? RESP : done ? IDLE : state_q;
        cnt_d   = accept ? CNT_W'(LATENCY - 1) : ((state_q == BUSY) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = rsp_valid_q;
        rsp_write = rsp_write_q;
        rsp_rdata = rsp_rdata_q;
    end

    always_comb begin
        rd_blk = '0;
        for (int j = 0; j < WORDS_PER_BLK; j++)
            rd_blk[j*DATA_W +: DATA_W] = mem_q[base_q | ADDR_W'(j)] ^ DATA_W'(base_q | ADDR_W'(j));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            base_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                base_q  <= req_addr & ~ADDR_W'(WORDS_PER_BLK - 1);
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= write_q;
                rsp_rdata_q <= write_q ? wdata_q : rd_blk;
            end else if (done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (access && write_q)
            for (int j = 0; j < WORDS_PER_BLK; j++)
                mem_q[base_q | ADDR_W'(j)] <= wdata_q[j*DATA_W +: DATA_W] ^ DATA_W'(base_q | ADDR_W'(j));
    end
endmodule

// File: tb/tb_block_mem_responder.sv
// tb_block_mem_responder: scoreboard bench with a word-array reference model of the block memory
module tb_block_mem_responder;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef logic [4*DW-1:0] blk_t;
    typedef struct {logic w; blk_t d; int acc;} want_t;

    logic          clk = 0, rst = 0;
    logic          req_valid = 0, req_ready, req_write = 0;
    logic [AW-1:0] req_addr = '0;
    blk_t          req_wdata = '0, rsp_rdata;
    logic          rsp_valid, rsp_ready = 1, rsp_write;
    logic          r1_req_valid = 0, r1_req_ready, r1_rsp_valid, r1_rsp_write;
    logic [AW-1:0] r1_req_addr = '0;
    blk_t          r1_rsp_rdata;

    always #5 clk = ~clk;

    block_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLK(4), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata)
    );

    block_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLK(4), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_write(1'b0),
        .req_addr(r1_req_addr), .req_wdata('0), .rsp_valid(r1_rsp_valid), .rsp_ready(1'b1),
        .rsp_write(r1_rsp_write), .rsp_rdata(r1_rsp_rdata)
    );

    int       errors = 0, checks = 0, cyc = 0;
    want_t    sbq[$];
    logic [DW-1:0] ref_mem [1 << AW];
    bit       in_rsp = 0, rnd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input blk_t got, input blk_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: whole-block read/write on a plain word array
    task automatic model(input bit w, input logic [AW-1:0] a, input blk_t wd, output blk_t blk);
        int b;
        b = (int'(a) / 4) * 4;
        for (int k = 0; k < 4; k++) begin
            if (w) ref_mem[b+k] = wd[k*DW +: DW];
            blk[k*DW +: DW] = ref_mem[b+k];
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %h with no request outstanding", rsp_rdata);
            end else begin
                if (!in_rsp) begin
                    check("latency", blk_t'(cyc - sbq[0].acc), blk_t'(LAT));
                    in_rsp = 1;
                end
                check("rsp_rdata", rsp_rdata, sbq[0].d);
                check("rsp_write", blk_t'(rsp_write), blk_t'(sbq[0].w));
                check("req_ready_in_resp", blk_t'(req_ready), '0);
                if (rsp_ready) begin
                    void'(sbq.pop_front());
                    in_rsp = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) check("idle_timeout", 1, 0);
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input blk_t wd);
        want_t e;
        wait_idle();
        req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        e.w = w;
        model(w, a, wd, e.d);
        e.acc = cyc;
        sbq.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        want_t e;
        int n;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i);
        #1 rst = 1;
        #11;
        check("reset_rsp_valid", blk_t'(rsp_valid), '0);
        check("reset_rsp_write", blk_t'(rsp_write), '0);
        check("reset_rsp_rdata", rsp_rdata, '0);
        check("reset_req_ready", blk_t'(req_ready), 1);
        @(posedge clk); #1;
        rst = 0;
        send(0, 24, '0);
        send(0, 25, '0);
        send(0, 27, '0);
        send(1, 28, {32'hD, 32'hC, 32'hB, 32'hA});
        send(0, 29, '0);
        // Back-pressure with a second request waiting the whole time
        wait_idle();
        rsp_ready = 0;
        send(0, 100, '0);
        req_valid = 1; req_write = 0; req_addr = 204;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_rsp_seen", blk_t'(rsp_valid), 1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_req_ready", blk_t'(req_ready), '0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        check("post_handshake_ready", blk_t'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        check("second_accept", blk_t'(req_ready), '0);
        e.w = 0;
        model(0, 204, '0, e.d);
        e.acc = cyc;
        sbq.push_back(e);
        // Reset mid-BUSY abandons the write to 32
        send(1, 40, {$urandom, $urandom, $urandom, $urandom});
        wait_idle();
        req_valid = 1; req_write = 1; req_addr = 32; req_wdata = {4{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("async_rst_valid", blk_t'(rsp_valid), '0);
        check("async_rst_write", blk_t'(rsp_write), '0);
        check("async_rst_rdata", rsp_rdata, '0);
        check("async_rst_ready", blk_t'(req_ready), 1);
        @(posedge clk); #1;
        rst = 0;
        send(0, 32, '0);
        rnd = 1;
        repeat (60) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
            send(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
        end
        rnd = 0;
        rsp_ready = 1;
        wait_idle();
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("scoreboard_empty", blk_t'(sbq.size()), '0);
        // LATENCY=1 instance, top block boundary
        r1_req_valid = 1; r1_req_addr = 15'h7FFF;
        @(posedge clk); #1;
        r1_req_valid = 0;
        check("l1_accepted", blk_t'(r1_req_ready), '0);
        check("l1_not_yet_valid", blk_t'(r1_rsp_valid), '0);
        @(posedge clk); #1;
        check("l1_valid", blk_t'(r1_rsp_valid), 1);
        check("l1_rdata", r1_rsp_rdata, {32'h7FFF, 32'h7FFE, 32'h7FFD, 32'h7FFC});
        check("l1_write", blk_t'(r1_rsp_write), '0);
        @(posedge clk); #1;
        check("l1_valid_drop", blk_t'(r1_rsp_valid), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
